// File: rtl/axi_prng_pkg.sv
// Shared constants for the AXI4-Lite PRNG slave: register map, CTRL bits, response codes
// and reset defaults.
package axi_prng_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_SEED    = 3'd1;
    localparam logic [2:0] REG_TAPS    = 3'd2;
    localparam logic [2:0] REG_SCRATCH = 3'd3;
    localparam logic [2:0] REG_RAND    = 3'd4;
    localparam logic [2:0] REG_COUNT   = 3'd5;

    localparam int unsigned CTRL_RUN        = 0;
    localparam int unsigned CTRL_STEP_ON_RD = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/prng_lfsr32.sv
// 32-bit Galois LFSR with seed load, advance enable and an advance counter.
module prng_lfsr32
    import axi_prng_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        adv,
    input  logic [31:0] taps,
    output logic [31:0] state,
    output logic [31:0] count
);

    logic [31:0] state_q, state_d;
    logic [31:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            // An all-zero state would lock the generator up.
            state_d = (load_val == 32'h0) ? 32'h0000_0001 : load_val;
            count_d = 32'h0;
        end else if (adv) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? taps : 32'h0);
            count_d = count_q + 32'h1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= RESET_SEED;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state = state_q;
    assign count = count_q;

endmodule

// File: rtl/axi_prng_lite_slave.sv
// AXI4-Lite slave with a small RW register file and a Galois LFSR random source.
// One outstanding write and one outstanding read; all responses are OKAY.
module axi_prng_lite_slave
    import axi_prng_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_RESET_SEED       = DEFAULT_SEED,
    parameter logic [31:0] C_RESET_TAPS       = DEFAULT_TAPS
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     prng_o
);

    logic        ready_en_q;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [2:0]  aw_idx_q, aw_idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] taps_q, taps_d;
    logic [31:0] scratch_q, scratch_d;
    logic        seed_load_q, seed_load_d;
    logic        rd_step_q, rd_step_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [2:0]  ar_idx;
    logic [31:0] rd_mux;
    logic [31:0] lfsr_state, lfsr_count;
    logic        lfsr_adv;

    // ready_en_q keeps every READY low until the first edge after reset release.
    assign S_AXI_AWREADY = ready_en_q & ~aw_held_q & ~bvalid_q;
    assign S_AXI_WREADY  = ready_en_q & ~w_held_q & ~bvalid_q;
    assign S_AXI_ARREADY = ready_en_q & ~rvalid_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_held_q & w_held_q;
    assign ar_idx = S_AXI_ARADDR[4:2];

    always_comb begin
        rd_mux = 32'h0;
        case (ar_idx)
            REG_CTRL:    rd_mux = ctrl_q;
            REG_SEED:    rd_mux = seed_q;
            REG_TAPS:    rd_mux = taps_q;
            REG_SCRATCH: rd_mux = scratch_q;
            REG_RAND:    rd_mux = lfsr_state;
            REG_COUNT:   rd_mux = lfsr_count;
            default:     rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        aw_idx_d    = aw_idx_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        seed_d      = seed_q;
        taps_d      = taps_q;
        scratch_d   = scratch_q;
        seed_load_d = 1'b0;
        rd_step_d   = 1'b0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            case (aw_idx_q)
                REG_CTRL:    ctrl_d    = apply_wstrb(ctrl_q, wdata_q, wstrb_q);
                REG_SEED: begin
                    seed_d      = apply_wstrb(seed_q, wdata_q, wstrb_q);
                    seed_load_d = 1'b1;
                end
                REG_TAPS:    taps_d    = apply_wstrb(taps_q, wdata_q, wstrb_q);
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, wdata_q, wstrb_q);
                default:     ;
            endcase
        end
        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

        if (ar_hs) begin
            rvalid_d  = 1'b1;
            rdata_d   = rd_mux;
            rd_step_d = (ar_idx == REG_RAND) & ctrl_q[CTRL_STEP_ON_RD];
        end
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_q  <= 1'b0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_idx_q    <= 3'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            ctrl_q      <= 32'h0;
            seed_q      <= C_RESET_SEED;
            taps_q      <= C_RESET_TAPS;
            scratch_q   <= 32'h0;
            seed_load_q <= 1'b0;
            rd_step_q   <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_idx_q    <= aw_idx_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            seed_q      <= seed_d;
            taps_q      <= taps_d;
            scratch_q   <= scratch_d;
            seed_load_q <= seed_load_d;
            rd_step_q   <= rd_step_d;
        end
    end

    // RUN wins outright, so a RAND read while running never adds a second step.
    assign lfsr_adv = ctrl_q[CTRL_RUN] | rd_step_q;

    prng_lfsr32 #(
        .RESET_SEED (C_RESET_SEED)
    ) u_lfsr (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .load     (seed_load_q),
        .load_val (seed_q),
        .adv      (lfsr_adv),
        .taps     (taps_q),
        .state    (lfsr_state),
        .count    (lfsr_count)
    );

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign prng_o       = lfsr_state;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_prng_lite_slave.sv
// Directed bench for axi_prng_lite_slave: register readback, read-stepped LFSR, byte strobes,
// zero seed, back-pressure and mid-transaction reset.
module tb_axi_prng_lite_slave;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] prng_o;

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    axi_prng_lite_slave dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .prng_o        (prng_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
            if (w_hs) begin S_AXI_WVALID = 1'b0; w_done = 1; end
            cyc++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("wr_addr_data_accepted", {30'h0, aw_done, w_done}, 32'h3);
        S_AXI_BREADY = 1'b1;
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 50) begin @(posedge ACLK); #1; cyc++; end
        check("wr_bresp", {29'h0, S_AXI_BVALID, S_AXI_BRESP}, 32'h4);
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        int cyc;
        bit hs;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            hs = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        S_AXI_ARVALID = 1'b0;
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 50) begin @(posedge ACLK); #1; cyc++; end
        check("rd_rresp", {29'h0, S_AXI_RVALID, S_AXI_RRESP}, 32'h4);
        d = S_AXI_RDATA;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        check("rst_valids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_prng_o", prng_o, 32'h1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("rel_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        read_check("rst_ctrl", 5'h00, 32'h0);
        read_check("rst_seed", 5'h04, 32'h1);
        read_check("rst_taps", 5'h08, 32'h8020_0003);
        read_check("rst_scratch", 5'h0C, 32'h0);
        read_check("rst_rand", 5'h10, 32'h1);
        read_check("rst_count", 5'h14, 32'h0);

        // Plain register writes and readback
        do_write(5'h00, 32'h1, 4'hF);
        do_write(5'h04, 32'h2, 4'hF);
        do_write(5'h08, 32'h3, 4'hF);
        do_write(5'h0C, 32'h4, 4'hF);
        read_check("rb_ctrl", 5'h00, 32'h1);
        read_check("rb_seed", 5'h04, 32'h2);
        read_check("rb_taps", 5'h08, 32'h3);
        read_check("rb_scratch", 5'h0C, 32'h4);
        do_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        read_check("unmapped_18", 5'h18, 32'h0);
        read_check("unmapped_1c", 5'h1C, 32'h0);

        // Step-on-read: stop RUN first, then seed so the state sits still
        do_write(5'h00, 32'h2, 4'hF);
        do_write(5'h08, 32'h8020_0003, 4'hF);
        do_write(5'h04, 32'h1, 4'hF);
        read_check("rand_0", 5'h10, 32'h0000_0001);
        read_check("rand_1", 5'h10, 32'h8020_0003);
        read_check("rand_2", 5'h10, 32'hC030_0002);
        read_check("count_3", 5'h14, 32'h3);
        check("prng_o_after_3", prng_o, 32'h6018_0001);

        // W two cycles ahead of AW with sparse strobes
        do_write(5'h0C, 32'h0, 4'hF);
        @(negedge ACLK);
        check("early_w_wready", {31'h0, S_AXI_WREADY}, 32'h1);
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'b0101; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_WVALID = 1'b0;
        check("early_w_latched", {30'h0, S_AXI_WREADY, S_AXI_AWREADY}, 32'h1);
        @(posedge ACLK); #1;
        check("early_w_no_b", {31'h0, S_AXI_BVALID}, 32'h0);
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        check("late_aw_no_b_yet", {31'h0, S_AXI_BVALID}, 32'h0);
        @(posedge ACLK); #1;
        check("late_aw_b", {31'h0, S_AXI_BVALID}, 32'h1);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        check("late_aw_b_done", {31'h0, S_AXI_BVALID}, 32'h0);
        repeat (4) begin
            @(posedge ACLK); #1;
            check("single_b", {31'h0, S_AXI_BVALID}, 32'h0);
        end
        read_check("strobe_scratch", 5'h0C, 32'h00AD_00EF);

        // Zero seed substitutes 1
        do_write(5'h04, 32'h0, 4'hF);
        read_check("zero_seed_count", 5'h14, 32'h0);
        read_check("zero_seed_rand", 5'h10, 32'h1);

        // Back-pressure on both channels; the read sees the pre-write SCRATCH
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        @(posedge ACLK); #1;
        for (int i = 0; i < 10; i++) begin
            check("stall_valids", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h3);
            check("stall_rdata", S_AXI_RDATA, 32'h00AD_00EF);
            check("stall_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
            @(posedge ACLK); #1;
        end
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        check("stall_release", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        @(posedge ACLK); #1;
        check("stall_readys_back", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        repeat (3) begin
            @(posedge ACLK); #1;
            check("stall_single_resp", {30'h0, S_AXI_BVALID, S_AXI_RVALID}, 32'h0);
        end
        read_check("stall_scratch", 5'h0C, 32'h1234_5678);

        // Reset while a write response is pending
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h3; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        @(posedge ACLK); #1;
        check("pre_rst_bvalid", {31'h0, S_AXI_BVALID}, 32'h1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("mid_rst_bvalid", {31'h0, S_AXI_BVALID}, 32'h0);
        check("mid_rst_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h0);
        check("mid_rst_prng_o", prng_o, 32'h1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        check("post_rst_readys", {29'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);
        check("post_rst_bvalid", {31'h0, S_AXI_BVALID}, 32'h0);
        read_check("post_rst_ctrl", 5'h00, 32'h0);
        read_check("post_rst_seed", 5'h04, 32'h1);
        read_check("post_rst_scratch", 5'h0C, 32'h0);
        read_check("post_rst_rand", 5'h10, 32'h1);
        read_check("post_rst_count", 5'h14, 32'h0);
        do_write(5'h0C, 32'hA5A5_A5A5, 4'hF);
        read_check("post_rst_write", 5'h0C, 32'hA5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
